// File: rtl/ocp_fetch_unit.sv
// rtl/ocp_fetch_unit.sv - pipelined OCP instruction-fetch master with address-tagged word FIFO
module ocp_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    BEN_WIDTH  = 4,
    parameter int                    FIFO_N2    = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_redirect,
    input  logic [ADDR_WIDTH-1:0] i_redirect_addr,
    output logic [ADDR_WIDTH-1:0] o_MAddr,
    output logic [2:0]            o_MCmd,
    output logic [DATA_WIDTH-1:0] o_MData,
    output logic [BEN_WIDTH-1:0]  o_MByteEn,
    input  logic                  i_SCmdAccept,
    input  logic [DATA_WIDTH-1:0] i_SData,
    input  logic [1:0]            i_SResp,
    output logic                  o_instr_valid,
    output logic [DATA_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH-1:0] o_instr_addr,
    input  logic                  i_instr_ready,
    output logic                  o_bus_err
);

    localparam int           DEPTH   = 2 ** FIFO_N2;
    localparam int           CW      = FIFO_N2 + 1;
    localparam logic [CW:0]  DEPTH_C = (CW + 1)'(DEPTH);

    localparam logic [2:0]   CMD_IDLE = 3'b000;
    localparam logic [2:0]   CMD_RD   = 3'b010;
    localparam logic [1:0]   RESP_DVA = 2'b01;
    localparam logic [1:0]   RESP_ERR = 2'b11;

    localparam logic [ADDR_WIDTH-1:0] WORD_STEP  = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

    // Fetch and response address counters
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] rsp_pc;

    // Reads accepted but not yet answered, and how many of those belong to a stale stream
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         discard;
    logic                  bus_err;

    // Word FIFO: data and its fetch address share pointers
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [FIFO_N2-1:0]    wr_ptr;
    logic [FIFO_N2-1:0]    rd_ptr;
    logic [CW-1:0]         fifo_count;

    logic                  rd_ok;
    logic                  accept;
    logic                  resp;
    logic                  push;
    logic                  pop;
    logic [CW:0]           credit_used;
    logic [CW-1:0]         out_next;
    logic [ADDR_WIDTH-1:0] redirect_pc;

    // Issue decision and per-cycle handshake events; a read is requested only while
    // buffered plus in-flight words leave room, so every response has a FIFO slot.
    // rst gates the command so nothing is requested while the shared slave is in reset.
    always_comb begin
        credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
        rd_ok       = !rst && !bus_err && (credit_used < DEPTH_C);
        accept      = rd_ok && i_SCmdAccept;
        resp        = (i_SResp != 2'b00);
        pop         = (fifo_count != '0) && i_instr_ready;
        push        = !i_redirect && resp && (discard == '0) && (i_SResp == RESP_DVA);
        out_next    = outstanding + CW'(accept) - CW'(resp);
        redirect_pc = i_redirect_addr & ALIGN_MASK;
    end

    // Control state: pc, response tracking, FIFO pointers, sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_ADDR;
            rsp_pc      <= RESET_ADDR;
            outstanding <= '0;
            discard     <= '0;
            bus_err     <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
        end else begin
            outstanding <= out_next;
            if (i_redirect) begin
                // Everything still in flight, including this cycle's accept, is stale
                pc         <= redirect_pc;
                rsp_pc     <= redirect_pc;
                discard    <= out_next;
                bus_err    <= 1'b0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
            end else begin
                if (accept) begin
                    pc <= pc + WORD_STEP;
                end
                if (resp) begin
                    if (discard != '0) begin
                        discard <= discard - CW'(1);
                    end else if (i_SResp == RESP_DVA) begin
                        rsp_pc <= rsp_pc + WORD_STEP;
                    end else if (i_SResp == RESP_ERR) begin
                        bus_err <= 1'b1;
                    end
                end
                if (push) begin
                    wr_ptr <= wr_ptr + FIFO_N2'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + FIFO_N2'(1);
                end
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
            end
        end
    end

    // FIFO storage write; contents need no reset since fifo_count qualifies them
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= i_SData;
            addr_mem[wr_ptr] <= rsp_pc;
        end
    end

    assign o_MAddr       = pc;
    assign o_MCmd        = rd_ok ? CMD_RD : CMD_IDLE;
    assign o_MData       = '0;
    assign o_MByteEn     = '1;
    assign o_instr_valid = (fifo_count != '0);
    assign o_instr       = data_mem[rd_ptr];
    assign o_instr_addr  = addr_mem[rd_ptr];
    assign o_bus_err     = bus_err;

endmodule

// File: tb/tb_ocp_fetch_unit.sv
// tb/tb_ocp_fetch_unit.sv - randomized self-checking bench for ocp_fetch_unit against a queue-based model
module tb_ocp_fetch_unit;

    localparam int         DEPTH = 4;
    localparam logic [1:0] R_NUL = 2'b00;
    localparam logic [1:0] R_DVA = 2'b01;
    localparam logic [1:0] R_ERR = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_redirect;
    logic [31:0] i_redirect_addr;
    logic [31:0] o_MAddr;
    logic [2:0]  o_MCmd;
    logic [31:0] o_MData;
    logic [3:0]  o_MByteEn;
    logic        i_SCmdAccept;
    logic [31:0] i_SData;
    logic [1:0]  i_SResp;
    logic        o_instr_valid;
    logic [31:0] o_instr;
    logic [31:0] o_instr_addr;
    logic        i_instr_ready;
    logic        o_bus_err;

    always #5 clk = ~clk;

    ocp_fetch_unit #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .BEN_WIDTH  (4),
        .FIFO_N2    (2),
        .RESET_ADDR (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_redirect      (i_redirect),
        .i_redirect_addr (i_redirect_addr),
        .o_MAddr         (o_MAddr),
        .o_MCmd          (o_MCmd),
        .o_MData         (o_MData),
        .o_MByteEn       (o_MByteEn),
        .i_SCmdAccept    (i_SCmdAccept),
        .i_SData         (i_SData),
        .i_SResp         (i_SResp),
        .o_instr_valid   (o_instr_valid),
        .o_instr         (o_instr),
        .o_instr_addr    (o_instr_addr),
        .i_instr_ready   (i_instr_ready),
        .o_bus_err       (o_bus_err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: what the consumer should see, as plain queues and counters
    logic [63:0] m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_rsp;
    int          m_out;
    int          m_disc;
    bit          m_err;
    bit          cur_rst;

    // Slave: in-order queue of accepted addresses, error window [err_lo, err_hi]
    logic [31:0] pend[$];
    logic [31:0] err_lo;
    logic [31:0] err_hi;
    int          n_acc;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    function automatic bit in_err(input logic [31:0] a);
        return (a >= err_lo) && (a <= err_hi);
    endfunction

    function automatic bit m_issue();
        return !m_err && ((m_q.size() + m_out) < DEPTH);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc   = 32'h0;
        m_rsp  = 32'h0;
        m_out  = 0;
        m_disc = 0;
        m_err  = 1'b0;
        pend.delete();
    endtask

    task automatic compare_all();
        chk("mcmd", {29'd0, o_MCmd}, (!cur_rst && m_issue()) ? 32'd2 : 32'd0);
        chk("maddr", o_MAddr, m_pc);
        chk("valid", {31'd0, o_instr_valid}, {31'd0, (m_q.size() > 0)});
        chk("bus_err", {31'd0, o_bus_err}, {31'd0, m_err});
        if (m_q.size() > 0) begin
            chk("instr_addr", o_instr_addr, m_q[0][63:32]);
            chk("instr", o_instr, m_q[0][31:0]);
        end
    endtask

    // One clock: check current outputs, drive this cycle's inputs, advance the model
    task automatic step(input bit r, input bit rdr, input logic [31:0] ra,
                        input bit rdy, input bit acc, input bit ren);
        logic [1:0]  resp;
        logic [31:0] sdata;
        logic [31:0] a;
        bit          issue;
        bit          accepted;
        compare_all();
        issue = !r && m_issue();
        resp  = R_NUL;
        sdata = $urandom;
        if (!r && ren && pend.size() > 0) begin
            a     = pend.pop_front();
            resp  = in_err(a) ? R_ERR : R_DVA;
            sdata = data_of(a);
        end
        rst             = r;
        i_redirect      = rdr;
        i_redirect_addr = rdr ? ra : $urandom;
        i_instr_ready   = rdy;
        i_SCmdAccept    = acc;
        i_SResp         = resp;
        i_SData         = sdata;
        accepted        = issue && acc;
        if (r) begin
            model_reset();
        end else begin
            if (accepted) begin
                pend.push_back(m_pc);
                n_acc++;
            end
            if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
            m_out = m_out + int'(accepted) - int'(resp != R_NUL);
            if (rdr) begin
                m_q.delete();
                m_pc   = ra & ~32'd3;
                m_rsp  = ra & ~32'd3;
                m_err  = 1'b0;
                m_disc = m_out;
            end else begin
                if (accepted) m_pc = m_pc + 32'd4;
                if (resp != R_NUL) begin
                    if (m_disc > 0) begin
                        m_disc--;
                    end else if (resp == R_DVA) begin
                        m_q.push_back({m_rsp, sdata});
                        m_rsp = m_rsp + 32'd4;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end
        end
        cur_rst = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_dut();
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
    endtask

    task automatic wait_valid(input string nm);
        int k;
        k = 0;
        while (!o_instr_valid && k < 40) begin
            step(0, 0, 0, 0, 1, 1);
            k++;
        end
        chk(nm, {31'd0, o_instr_valid}, 32'd1);
    endtask

    initial begin
        logic [31:0] ra;
        rst = 1'b1; i_redirect = 1'b0; i_redirect_addr = '0; i_instr_ready = 1'b0;
        i_SCmdAccept = 1'b0; i_SData = '0; i_SResp = R_NUL;
        err_lo = 32'd1; err_hi = 32'd0; n_acc = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        cur_rst = 1'b1;

        // Reset state and first-word latency with a one-cycle slave
        reset_dut();
        chk("rst_mcmd", {29'd0, o_MCmd}, 32'd0);
        chk("rst_valid", {31'd0, o_instr_valid}, 32'd0);
        chk("rst_err", {31'd0, o_bus_err}, 32'd0);
        chk("rst_maddr", o_MAddr, 32'h0);
        chk("mdata", o_MData, 32'h0);
        chk("mbyteen", {28'd0, o_MByteEn}, 32'hF);
        step(0, 0, 0, 1, 1, 1);
        chk("lat_c1_valid", {31'd0, o_instr_valid}, 32'd0);
        chk("lat_c1_maddr", o_MAddr, 32'h4);
        step(0, 0, 0, 1, 1, 1);
        chk("lat_c2_valid", {31'd0, o_instr_valid}, 32'd1);
        chk("lat_c2_addr", o_instr_addr, 32'h0);
        step(0, 0, 0, 1, 1, 1);
        chk("lat_c3_addr", o_instr_addr, 32'h4);
        step(0, 0, 0, 1, 1, 1);
        chk("lat_c4_addr", o_instr_addr, 32'h8);
        chk("lat_c4_data", o_instr, 32'h8 ^ 32'hA5A5_5A5A);

        // Consumer stalled: exactly DEPTH reads, then idle
        reset_dut();
        n_acc = 0;
        repeat (20) step(0, 0, 0, 0, 1, 1);
        chk("stall_accepts", n_acc, 32'd4);
        chk("stall_mcmd", {29'd0, o_MCmd}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("stall_pop_addr", o_instr_addr, 32'(i * 4));
            step(0, 0, 0, 1, 0, 0);
        end
        chk("stall_drained", {31'd0, o_instr_valid}, 32'd0);

        // Slave withholds SCmdAccept: request held stable
        reset_dut();
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 1, 0, 1);
            chk("hold_mcmd", {29'd0, o_MCmd}, 32'd2);
            chk("hold_maddr", o_MAddr, 32'h0);
        end
        step(0, 0, 0, 1, 1, 0);
        chk("hold_accepts", n_acc, 32'd1);
        chk("hold_next_maddr", o_MAddr, 32'h4);

        // Redirect with 2 buffered and 2 in flight
        reset_dut();
        repeat (4) step(0, 0, 0, 0, 1, 0);
        repeat (2) step(0, 0, 0, 0, 1, 1);
        chk("redir_pre_valid", {31'd0, o_instr_valid}, 32'd1);
        step(0, 1, 32'h103, 0, 1, 0);
        chk("redir_valid_drop", {31'd0, o_instr_valid}, 32'd0);
        chk("redir_maddr", o_MAddr, 32'h100);
        wait_valid("redir_wait");
        chk("redir_addr", o_instr_addr, 32'h100);
        chk("redir_data", o_instr, 32'h100 ^ 32'hA5A5_5A5A);

        // Bus error at 0x8: sticky, earlier words still delivered, redirect recovers
        reset_dut();
        err_lo = 32'h8; err_hi = 32'h1F;
        repeat (12) step(0, 0, 0, 0, 1, 1);
        chk("err_sticky", {31'd0, o_bus_err}, 32'd1);
        chk("err_mcmd", {29'd0, o_MCmd}, 32'd0);
        chk("err_head0", o_instr_addr, 32'h0);
        step(0, 0, 0, 1, 1, 1);
        chk("err_head1", o_instr_addr, 32'h4);
        step(0, 0, 0, 1, 1, 1);
        chk("err_empty", {31'd0, o_instr_valid}, 32'd0);
        step(0, 1, 32'h20, 0, 1, 1);
        chk("err_cleared", {31'd0, o_bus_err}, 32'd0);
        chk("err_resume_mcmd", {29'd0, o_MCmd}, 32'd2);
        wait_valid("err_resume_wait");
        chk("err_resume_addr", o_instr_addr, 32'h20);
        err_lo = 32'd1; err_hi = 32'd0;

        // Address wrap at the top of the space
        step(0, 1, 32'hFFFF_FFF8, 0, 1, 1);
        repeat (12) step(0, 0, 0, 0, 1, 1);
        chk("wrap_a0", o_instr_addr, 32'hFFFF_FFF8);
        step(0, 0, 0, 1, 0, 0);
        chk("wrap_a1", o_instr_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 1, 0, 0);
        chk("wrap_a2", o_instr_addr, 32'h0);
        step(0, 0, 0, 1, 0, 0);
        chk("wrap_a3", o_instr_addr, 32'h4);

        // Reset mid-stream with the FIFO full
        repeat (10) step(0, 0, 0, 0, 1, 1);
        chk("full_valid", {31'd0, o_instr_valid}, 32'd1);
        step(1, 0, 0, 0, 1, 1);
        chk("midrst_valid", {31'd0, o_instr_valid}, 32'd0);
        chk("midrst_err", {31'd0, o_bus_err}, 32'd0);
        chk("midrst_maddr", o_MAddr, 32'h0);
        chk("midrst_mcmd", {29'd0, o_MCmd}, 32'd0);

        // Randomized traffic
        reset_dut();
        for (int c = 0; c < 4000; c++) begin
            if (c % 400 == 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    err_lo = 32'($urandom_range(0, 32'h1F0)) & ~32'd3;
                    err_hi = err_lo + 32'($urandom_range(0, 15));
                end else begin
                    err_lo = 32'd1; err_hi = 32'd0;
                end
            end
            case ($urandom_range(0, 2))
                0:       ra = 32'($urandom_range(0, 32'h1FF));
                1:       ra = 32'hFFFF_FFE0 + 32'($urandom_range(0, 31));
                default: ra = $urandom;
            endcase
            step(($urandom_range(0, 699) == 0),
                 ($urandom_range(0, 24) == 0),
                 ra,
                 ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) < 7));
        end
        compare_all();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
